// File: rtl/acc_capture_sequencer.sv
// acc_capture_sequencer
//   Run-control sequencer for the accumulator datapath (counter, four I/Q
//   accumulators, serializer). It accepts one capture command per valid/ready
//   handshake, loads the down-sampling ratio, holds the datapath in clear while
//   it settles, counts accumulation frames, waits for the serializer to drain
//   and then pulses done.
//
// Ports
//   clk            system clock
//   reset          asynchronous reset, active-low
//   cmd_valid      capture command present
//   cmd_ready      high only while idle; command accepted on cmd_valid & cmd_ready
//   cmd_ds_ratio   requested down-sampling ratio (values below 2 are rejected)
//   cmd_num_frames frames to capture; 0 = continuous until abort
//   abort          level; stops the current capture
//   frame_valid    one-cycle pulse per completed accumulation frame
//   ser_busy       serializer is still shifting out a frame
//   ds_ratio       down-sampling ratio driven to the datapath
//   acc_clear      active-high clear for counter and accumulators
//   busy           capture in progress (any state except idle)
//   frame_count    frames counted in the current or last capture
//   done           one-cycle pulse at the end of a capture
//   aborted        capture ended by abort; valid from done until next accept
//   cmd_err        one-cycle pulse: command rejected
module acc_capture_sequencer #(
  parameter int ACC_WIDTH     = 16,
  parameter int FRAME_WIDTH   = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEFAULT_RATIO = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ACC_WIDTH-1:0]   cmd_ds_ratio,
  input  logic [FRAME_WIDTH-1:0] cmd_num_frames,
  input  logic                   abort,
  input  logic                   frame_valid,
  input  logic                   ser_busy,
  output logic [ACC_WIDTH-1:0]   ds_ratio,
  output logic                   acc_clear,
  output logic                   busy,
  output logic [FRAME_WIDTH-1:0] frame_count,
  output logic                   done,
  output logic                   aborted,
  output logic                   cmd_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [2:0]             stateReg;
  logic [ACC_WIDTH-1:0]   dsRatioReg;
  logic [ACC_WIDTH-1:0]   ratioLatchReg;
  logic [FRAME_WIDTH-1:0] numFramesReg;
  logic [FRAME_WIDTH-1:0] frameCountReg;
  logic [SETTLE_W-1:0]    settleCntReg;
  logic                   accClearReg;
  logic                   doneReg;
  logic                   abortedReg;
  logic                   cmdErrReg;

  logic [FRAME_WIDTH-1:0] frameCountNext;
  logic                   targetReached;

  // Saturating frame counter increment; the target compare uses the
  // incremented value so the last frame moves straight to DRAIN.
  always_comb begin
    frameCountNext = frameCountReg;
    if (frameCountReg != '1) begin
      frameCountNext = frameCountReg + 1'b1;
    end
    targetReached = (numFramesReg != '0) && (frameCountNext == numFramesReg);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg      <= IDLE;
      dsRatioReg    <= ACC_WIDTH'(DEFAULT_RATIO);
      ratioLatchReg <= ACC_WIDTH'(DEFAULT_RATIO);
      numFramesReg  <= '0;
      frameCountReg <= '0;
      settleCntReg  <= '0;
      accClearReg   <= 1'b1;
      doneReg       <= 1'b0;
      abortedReg    <= 1'b0;
      cmdErrReg     <= 1'b0;
    end else begin
      doneReg   <= 1'b0;
      cmdErrReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          accClearReg <= 1'b1;
          if (cmd_valid) begin
            if (cmd_ds_ratio < ACC_WIDTH'(2)) begin
              cmdErrReg <= 1'b1;
            end else begin
              ratioLatchReg <= cmd_ds_ratio;
              numFramesReg  <= cmd_num_frames;
              frameCountReg <= '0;
              abortedReg    <= 1'b0;
              stateReg      <= LOAD;
            end
          end
        end
        LOAD: begin
          dsRatioReg  <= ratioLatchReg;
          accClearReg <= 1'b1;
          if (abort) begin
            abortedReg <= 1'b1;
            doneReg    <= 1'b1;
            stateReg   <= DONE;
          end else begin
            settleCntReg <= SETTLE_W'(SETTLE_CYCLES - 1);
            stateReg     <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            abortedReg <= 1'b1;
            doneReg    <= 1'b1;
            stateReg   <= DONE;
          end else if (settleCntReg == '0) begin
            accClearReg <= 1'b0;
            stateReg    <= RUN;
          end else begin
            settleCntReg <= settleCntReg - 1'b1;
          end
        end
        RUN: begin
          accClearReg <= 1'b0;
          // A frame arriving with abort is still counted.
          if (frame_valid) begin
            frameCountReg <= frameCountNext;
          end
          if (abort) begin
            abortedReg <= 1'b1;
            stateReg   <= DRAIN;
          end else if (frame_valid && targetReached) begin
            stateReg <= DRAIN;
          end
        end
        DRAIN: begin
          if (!ser_busy) begin
            accClearReg <= 1'b1;
            doneReg     <= 1'b1;
            stateReg    <= DONE;
          end
        end
        DONE: begin
          accClearReg <= 1'b1;
          stateReg    <= IDLE;
        end
        default: begin
          accClearReg <= 1'b1;
          stateReg    <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (stateReg == IDLE);
  assign busy        = (stateReg != IDLE);
  assign ds_ratio    = dsRatioReg;
  assign acc_clear   = accClearReg;
  assign frame_count = frameCountReg;
  assign done        = doneReg;
  assign aborted     = abortedReg;
  assign cmd_err     = cmdErrReg;

endmodule

// File: tb/tb_acc_capture_sequencer.sv
// Directed bench for acc_capture_sequencer with a completion scoreboard:
// each command pushes its expected outcome, and a monitor pops and checks it
// when done or cmd_err pulses.
module tb_acc_capture_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_ds_ratio;
  logic [15:0] cmd_num_frames;
  logic        abort;
  logic        frame_valid;
  logic        ser_busy;
  logic [15:0] ds_ratio;
  logic        acc_clear;
  logic        busy;
  logic [15:0] frame_count;
  logic        done;
  logic        aborted;
  logic        cmd_err;

  acc_capture_sequencer #(
    .ACC_WIDTH(16), .FRAME_WIDTH(16), .SETTLE_CYCLES(4), .DEFAULT_RATIO(16)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ds_ratio(cmd_ds_ratio), .cmd_num_frames(cmd_num_frames),
    .abort(abort), .frame_valid(frame_valid), .ser_busy(ser_busy),
    .ds_ratio(ds_ratio), .acc_clear(acc_clear), .busy(busy),
    .frame_count(frame_count), .done(done), .aborted(aborted), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        isErr;
    logic [15:0] expCount;
    logic        expAborted;
  } sb_t;

  sb_t sbQ[$];
  int  errors = 0;
  int  checks = 0;
  int  doneSeen = 0;
  int  acceptSeen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushDone(input logic [15:0] cnt, input logic ab);
    sb_t e;
    e.isErr = 1'b0; e.expCount = cnt; e.expAborted = ab;
    sbQ.push_back(e);
  endtask

  task automatic pushErr();
    sb_t e;
    e.isErr = 1'b1; e.expCount = '0; e.expAborted = 1'b0;
    sbQ.push_back(e);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  // Count handshakes as the design sees them at the clock edge.
  always @(posedge clk) begin
    if (reset && cmd_valid && cmd_ready) acceptSeen++;
  end

  // Scoreboard monitor: sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    if (reset && (done || cmd_err)) begin
      if (done) doneSeen++;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected observed done=%0b cmd_err=%0b required=no_event", done, cmd_err);
      end else begin
        sb_t e;
        e = sbQ.pop_front();
        check("sb_kind", {31'd0, cmd_err}, {31'd0, e.isErr});
        if (!e.isErr) begin
          check("sb_frame_count", {16'd0, frame_count}, {16'd0, e.expCount});
          check("sb_aborted", {31'd0, aborted}, {31'd0, e.expAborted});
        end
        $display("sb event err=%0b frame_count=%0d aborted=%0b", cmd_err, frame_count, aborted);
      end
    end
  end

  initial begin
    int d0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_ds_ratio = '0; cmd_num_frames = '0;
    abort = 1'b0; frame_valid = 1'b0; ser_busy = 1'b0;

    // 1: reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ds_ratio", {16'd0, ds_ratio}, 32'd16);
    check("rst_acc_clear", {31'd0, acc_clear}, 32'd1);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {29'd0, done, cmd_err, aborted}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    // 2: ratio 8, 3 frames, serializer idle
    d0 = doneSeen;
    cmd_valid = 1'b1; cmd_ds_ratio = 16'd8; cmd_num_frames = 16'd3;
    pushDone(16'd3, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("t2_busy_after_accept", {30'd0, busy, cmd_ready}, 32'd2);
    repeat (4) tick();
    check("t2_clear_still_high", {31'd0, acc_clear}, 32'd1);
    check("t2_ratio_loaded", {16'd0, ds_ratio}, 32'd8);
    tick();
    check("t2_clear_fell", {31'd0, acc_clear}, 32'd0);
    // command offered while busy must be ignored
    cmd_valid = 1'b1; cmd_ds_ratio = 16'd5; cmd_num_frames = 16'd1;
    repeat (2) tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (6) tick();
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
    end
    check("t2_frame_count", {16'd0, frame_count}, 32'd3);
    check("t2_no_early_done", {31'd0, done}, 32'd0);
    tick();
    check("t2_done_pulse", {31'd0, done}, 32'd1);
    tick();
    check("t2_done_single", {31'd0, done}, 32'd0);
    waitIdle("t2_idle_timeout", 20);
    check("t2_done_count", doneSeen, d0 + 1);
    check("t2_ratio_held", {16'd0, ds_ratio}, 32'd8);
    check("t2_accepts", acceptSeen, 32'd1);

    // 3: ratio 1 rejected
    cmd_valid = 1'b1; cmd_ds_ratio = 16'd1; cmd_num_frames = 16'd2;
    pushErr();
    tick();
    cmd_valid = 1'b0;
    check("t3_cmd_err", {31'd0, cmd_err}, 32'd1);
    check("t3_stays_idle", {30'd0, busy, cmd_ready}, 32'd1);
    check("t3_ratio_unchanged", {16'd0, ds_ratio}, 32'd8);
    tick();
    check("t3_cmd_err_pulse", {31'd0, cmd_err}, 32'd0);

    // 4: continuous, abort with the 5th frame, serializer drains 10 cycles
    cmd_valid = 1'b1; cmd_ds_ratio = 16'd4; cmd_num_frames = 16'd0;
    pushDone(16'd5, 1'b1);
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    check("t4_run", {31'd0, acc_clear}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      repeat (3) tick();
      frame_valid = 1'b1;
      if (i == 4) begin
        abort = 1'b1;
        ser_busy = 1'b1;
      end
      tick();
      frame_valid = 1'b0;
      abort = 1'b0;
    end
    check("t4_frame_count", {16'd0, frame_count}, 32'd5);
    check("t4_aborted", {31'd0, aborted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      frame_valid = (i == 3);
      tick();
    end
    frame_valid = 1'b0;
    check("t4_drain_ignores_frame", {16'd0, frame_count}, 32'd5);
    check("t4_waiting_drain", {30'd0, busy, done}, 32'd2);
    ser_busy = 1'b0;
    tick();
    check("t4_done_after_drain", {31'd0, done}, 32'd1);
    tick();
    check("t4_idle", {31'd0, busy}, 32'd0);

    // 5: abort during SETTLE, then a normal command
    cmd_valid = 1'b1; cmd_ds_ratio = 16'd6; cmd_num_frames = 16'd2;
    pushDone(16'd0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_aborted", {31'd0, aborted}, 32'd1);
    check("t5_frame_count", {16'd0, frame_count}, 32'd0);
    tick();
    cmd_valid = 1'b1; cmd_ds_ratio = 16'd3; cmd_num_frames = 16'd1;
    pushDone(16'd1, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("t5b_aborted_cleared", {31'd0, aborted}, 32'd0);
    repeat (5) tick();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    waitIdle("t5b_idle_timeout", 20);
    check("t5b_ratio", {16'd0, ds_ratio}, 32'd3);

    // 6: reset in RUN with frame_count=2
    cmd_valid = 1'b1; cmd_ds_ratio = 16'd10; cmd_num_frames = 16'd0;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 2; i++) begin
      repeat (2) tick();
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
    end
    check("t6_pre_reset", {15'd0, busy, frame_count}, {15'd0, 1'b1, 16'd2});
    reset = 1'b0;
    #1;
    check("t6_rst_ratio", {16'd0, ds_ratio}, 32'd16);
    check("t6_rst_state", {28'd0, acc_clear, busy, cmd_ready, done}, 32'b1010);
    check("t6_rst_count", {16'd0, frame_count}, 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    check("sb_drained", sbQ.size(), 32'd0);
    check("total_accepts", acceptSeen, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
